// File: rtl/four_bit_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives operands; the slave (the adder) returns registered results.
interface four_bit_adder_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             out_valid;

  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, overflow, zero, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, overflow, zero, out_valid
  );
endinterface

// File: rtl/four_bit_adder.sv
// Registered ripple-carry adder: a chain of full-adder cells followed by one
// output register stage carrying sum, carry, overflow and zero flags.
module four_bit_adder #(
  parameter int unsigned WIDTH = 4
) (
  input logic             clk,
  input logic             rst,
  four_bit_adder_if.slave bus
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  // Carry ripples LSB to MSB; one process keeps the chain free of feedback loops.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = bus.cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      s[i]   = bus.a[i] ^ bus.b[i] ^ c[i];
      c[i+1] = (bus.a[i] & bus.b[i]) | (c[i] & (bus.a[i] ^ bus.b[i]));
    end
  end

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;

  // Results hold while idle so X on idle operands never reaches the outputs.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    valid_d = 1'b0;
    if (bus.in_valid) begin
      sum_d   = s;
      cout_d  = c[WIDTH];
      ovf_d   = c[WIDTH] ^ c[WIDTH-1];
      zero_d  = (s == '0);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_four_bit_adder.sv
// Self-checking bench for four_bit_adder: directed steps plus random vectors,
// checked against an arithmetic reference model of the registered adder.
module tb_four_bit_adder;
  localparam int unsigned WIDTH = 4;
  localparam int          FULL  = 1 << WIDTH;
  localparam int          HALF  = 1 << (WIDTH - 1);

  logic clk = 1'b0;
  logic rst;

  four_bit_adder_if #(.WIDTH(WIDTH)) bus ();

  four_bit_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] m_sum = '0;
  logic             m_cout = 1'b0;
  logic             m_ovf = 1'b0;
  logic             m_zero = 1'b0;
  logic             m_valid = 1'b0;

  // Reference model: what the registers hold after one rising edge.
  task automatic model_edge(input logic r, input logic v, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic ci);
    int full;
    int sa;
    int sb;
    int sr;
    if (r) begin
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
      m_zero  = 1'b0;
      m_valid = 1'b0;
    end else if (v) begin
      full    = int'(a) + int'(b) + int'(ci);
      m_sum   = WIDTH'(full % FULL);
      m_cout  = (full >= FULL);
      sa      = (int'(a) >= HALF) ? int'(a) - FULL : int'(a);
      sb      = (int'(b) >= HALF) ? int'(b) - FULL : int'(b);
      sr      = sa + sb + int'(ci);
      m_ovf   = (sr > HALF - 1) || (sr < -HALF);
      m_zero  = (m_sum == '0);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check(input string tag);
    n_checks++;
    assert (bus.out_valid === m_valid) else begin
      n_errors++;
      $error("FAIL %s out_valid: got %b expected %b", tag, bus.out_valid, m_valid);
    end
    n_checks++;
    assert (bus.sum === m_sum) else begin
      n_errors++;
      $error("FAIL %s sum: got %0d expected %0d", tag, bus.sum, m_sum);
    end
    n_checks++;
    assert (bus.cout === m_cout) else begin
      n_errors++;
      $error("FAIL %s cout: got %b expected %b", tag, bus.cout, m_cout);
    end
    n_checks++;
    assert (bus.overflow === m_ovf) else begin
      n_errors++;
      $error("FAIL %s overflow: got %b expected %b", tag, bus.overflow, m_ovf);
    end
    n_checks++;
    assert (bus.zero === m_zero) else begin
      n_errors++;
      $error("FAIL %s zero: got %b expected %b", tag, bus.zero, m_zero);
    end
  endtask

  // Fixed expectations taken straight from worked examples.
  task automatic expect_sum(input string tag, input logic [WIDTH-1:0] exp_sum,
                            input logic exp_cout);
    n_checks++;
    assert (bus.sum === exp_sum && bus.cout === exp_cout) else begin
      n_errors++;
      $error("FAIL %s literal: got sum=%0d cout=%b expected sum=%0d cout=%b", tag, bus.sum,
             bus.cout, exp_sum, exp_cout);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic ci, input string tag);
    rst          = r;
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = ci;
    @(posedge clk);
    #1;
    model_edge(r, v, a, b, ci);
    check(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] xv;
    xv           = 'x;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;

    // Reset wins over a valid input.
    step(1'b1, 1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "reset0");
    step(1'b1, 1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "reset1");
    step(1'b0, 1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "post_reset0");
    step(1'b0, 1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "post_reset1");

    step(1'b0, 1'b1, 4'd0, 4'd0, 1'b1, "cin_path");
    expect_sum("cin_path", 4'd1, 1'b0);

    step(1'b0, 1'b1, 4'd2, 4'd12, 1'b0, "stream0");
    expect_sum("stream0", 4'd14, 1'b0);
    step(1'b0, 1'b1, 4'd10, 4'd5, 1'b0, "stream1");
    expect_sum("stream1", 4'd15, 1'b0);
    step(1'b0, 1'b1, 4'd6, 4'd9, 1'b0, "stream2");
    expect_sum("stream2", 4'd15, 1'b0);
    step(1'b0, 1'b1, 4'd2, 4'd4, 1'b0, "stream3");
    expect_sum("stream3", 4'd6, 1'b0);
    step(1'b0, 1'b1, 4'd8, 4'd5, 1'b0, "stream4");
    expect_sum("stream4", 4'd13, 1'b0);

    step(1'b0, 1'b1, 4'd15, 4'd1, 1'b0, "wrap");
    expect_sum("wrap", 4'd0, 1'b1);
    step(1'b0, 1'b1, 4'd7, 4'd1, 1'b0, "ovf_pos");
    expect_sum("ovf_pos", 4'd8, 1'b0);
    step(1'b0, 1'b1, 4'd15, 4'd15, 1'b1, "max_add");
    expect_sum("max_add", 4'd15, 1'b1);

    step(1'b0, 1'b1, 4'd3, 4'd4, 1'b0, "hold_load");
    expect_sum("hold_load", 4'd7, 1'b0);
    step(1'b0, 1'b0, xv, xv, 1'bx, "hold_x");
    step(1'b0, 1'b0, 4'd9, 4'd11, 1'b1, "hold_idle1");
    step(1'b0, 1'b0, 4'd15, 4'd15, 1'b1, "hold_idle2");
    expect_sum("hold_idle2", 4'd7, 1'b0);

    step(1'b1, 1'b1, 4'd9, 4'd9, 1'b0, "reset_mid");
    step(1'b0, 1'b1, 4'd1, 4'd1, 1'b0, "after_reset");
    expect_sum("after_reset", 4'd2, 1'b0);

    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0), WIDTH'($urandom),
           WIDTH'($urandom), 1'($urandom), "random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
